// File: rtl/axil_mem_slave_if.sv
// AXI-Lite channel bundle shared by the fetch/data masters and the memory subordinate.
interface axil_interface #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0]   awaddr;
   logic              awvalid;
   logic              awready;
   logic [XLEN-1:0]   wdata;
   logic [XLEN/8-1:0] wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [XLEN-1:0]   araddr;
   logic              arvalid;
   logic              arready;
   logic [XLEN-1:0]   rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport axil_slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport axil_master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axil_mem_slave.sv
// AXI-Lite subordinate over a single-port word RAM; read data 2 cycles after AR accept, write on first free IDLE edge.
// Backpressure: AR only accepted in IDLE when the read wins; AW/W stall while their one-entry holding register is full.
module axil_mem_slave #(
   parameter int unsigned MEM_DEPTH = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input logic               clk,
   input logic               rst_n,
   axil_interface.axil_slave axil_bus
);
   localparam int unsigned IW = $clog2(MEM_DEPTH);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RD_MEM  = 2'd1;
   localparam logic [1:0] S_RD_RESP = 2'd2;
   localparam logic [1:0] S_WR_RESP = 2'd3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [1:0]    state;
   logic          aw_held;
   logic          w_held;
   logic [31:2]   aw_addr_q;
   logic [31:0]   w_data_q;
   logic [3:0]    w_strb_q;
   logic          last_grant_wr;
   logic          ar_ok_q;
   logic [31:0]   ram_q;
   logic [31:0]   rdata_q;
   logic [1:0]    rresp_q;
   logic [1:0]    bresp_q;
   logic [31:0]   mem [MEM_DEPTH];

   logic          idle;
   logic          wr_pending;
   logic          read_wins;
   logic          rd_go;
   logic          wr_go;
   logic          aw_fire;
   logic          w_fire;
   logic          wr_ok;
   logic          rd_ok;
   logic [IW-1:0] ram_idx;
   logic          unused_addr_lsbs;

   // BASE_ADDR is aligned to the RAM size, so decode is a compare of the bits above the index.
   assign wr_ok = aw_addr_q[31:IW+2] == BASE_ADDR[31:IW+2];
   assign rd_ok = axil_bus.araddr[31:IW+2] == BASE_ADDR[31:IW+2];
   assign unused_addr_lsbs = ^{axil_bus.araddr[1:0], axil_bus.awaddr[1:0]};

   assign idle       = (state == S_IDLE);
   assign wr_pending = aw_held & w_held;
   assign read_wins  = ~wr_pending | last_grant_wr;

   assign axil_bus.arready = rst_n & idle & read_wins;
   assign axil_bus.awready = rst_n & ~aw_held;
   assign axil_bus.wready  = rst_n & ~w_held;

   assign rd_go   = axil_bus.arvalid & axil_bus.arready;
   assign wr_go   = idle & wr_pending & ~(axil_bus.arvalid & read_wins);
   assign aw_fire = axil_bus.awvalid & axil_bus.awready;
   assign w_fire  = axil_bus.wvalid & axil_bus.wready;

   assign ram_idx = wr_go ? aw_addr_q[IW+1:2] : axil_bus.araddr[IW+1:2];

   assign axil_bus.rvalid = (state == S_RD_RESP);
   assign axil_bus.bvalid = (state == S_WR_RESP);
   assign axil_bus.rdata  = rdata_q;
   assign axil_bus.rresp  = rresp_q;
   assign axil_bus.bresp  = bresp_q;

   // Single port: the grant logic guarantees rd_go and wr_go never coincide.
   always_ff @(posedge clk) begin
      if (wr_go && wr_ok) begin
         for (int i = 0; i < 4; i++) begin
            if (w_strb_q[i]) mem[ram_idx][8*i +: 8] <= w_data_q[8*i +: 8];
         end
      end
      if (rd_go) ram_q <= mem[ram_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_held   <= 1'b0;
         aw_addr_q <= '0;
         w_held    <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
      end else begin
         if (aw_fire) begin
            aw_held   <= 1'b1;
            aw_addr_q <= axil_bus.awaddr[31:2];
         end else if (wr_go) begin
            aw_held <= 1'b0;
         end
         if (w_fire) begin
            w_held   <= 1'b1;
            w_data_q <= axil_bus.wdata;
            w_strb_q <= axil_bus.wstrb;
         end else if (wr_go) begin
            w_held <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         last_grant_wr <= 1'b1;
         ar_ok_q       <= 1'b0;
         rdata_q       <= '0;
         rresp_q       <= RESP_OKAY;
         bresp_q       <= RESP_OKAY;
      end else begin
         case (state)
            S_IDLE: begin
               if (rd_go) begin
                  ar_ok_q       <= rd_ok;
                  last_grant_wr <= 1'b0;
                  state         <= S_RD_MEM;
               end else if (wr_go) begin
                  bresp_q       <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                  last_grant_wr <= 1'b1;
                  state         <= S_WR_RESP;
               end
            end
            S_RD_MEM: begin
               rdata_q <= ar_ok_q ? ram_q : 32'h0;
               rresp_q <= ar_ok_q ? RESP_OKAY : RESP_SLVERR;
               state   <= S_RD_RESP;
            end
            S_RD_RESP: if (axil_bus.rready) state <= S_IDLE;
            S_WR_RESP: if (axil_bus.bready) state <= S_IDLE;
            default:   state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axil_mem_slave.sv
// Directed bench for axil_mem_slave: vector table plus skew, contention, backpressure and reset sequences.
module tb_axil_mem_slave;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   axil_interface #(.XLEN(32)) bus ();

   axil_mem_slave #(.MEM_DEPTH(1024), .BASE_ADDR(32'h0000_0000)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .axil_bus (bus)
   );

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vec [NVEC];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output int lat);
      int n;
      logic aw_f, w_f;
      bus.awaddr  = addr;
      bus.wdata   = data;
      bus.wstrb   = strb;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      n = 0;
      while ((bus.awvalid || bus.wvalid) && n < 20) begin
         aw_f = bus.awvalid & bus.awready;
         w_f  = bus.wvalid & bus.wready;
         tick;
         if (aw_f) bus.awvalid = 1'b0;
         if (w_f)  bus.wvalid  = 1'b0;
         n++;
      end
      lat = 0;
      while (!bus.bvalid && lat < 20) begin
         tick;
         lat++;
      end
      resp = bus.bresp;
      bus.bready = 1'b1;
      tick;
      bus.bready = 1'b0;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output int lat);
      int n;
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      n = 0;
      while (!bus.arready && n < 20) begin
         tick;
         n++;
      end
      tick;
      bus.arvalid = 1'b0;
      lat = 0;
      while (!bus.rvalid && lat < 20) begin
         tick;
         lat++;
      end
      data = bus.rdata;
      resp = bus.rresp;
      bus.rready = 1'b1;
      tick;
      bus.rready = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;

      checks = 0;
      errors = 0;
      vec[0]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0};
      vec[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
      vec[2]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
      vec[3]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 2'b00, 32'h0};
      vec[4]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0};
      vec[5]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 2'b00, 32'h11BB_33DD};
      vec[6]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 2'b10, 32'h0};
      vec[7]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 2'b10, 32'h0};
      vec[8]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D};
      vec[9]  = '{1'b1, 32'h0000_0013, 32'h0102_0304, 4'hF, 2'b00, 32'h0};
      vec[10] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 2'b00, 32'h0102_0304};
      vec[11] = '{1'b1, 32'h0000_0024, 32'h5566_7788, 4'hF, 2'b00, 32'h0};
      vec[12] = '{1'b1, 32'h0000_0024, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0};
      vec[13] = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 2'b00, 32'h5566_7788};
      vec[14] = '{1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 4'hF, 2'b00, 32'h0};
      vec[15] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 2'b00, 32'hA5A5_A5A5};
      vec[16] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 2'b10, 32'h0};
      vec[17] = '{1'b1, 32'h0000_0040, 32'h1212_1212, 4'hF, 2'b00, 32'h0};

      rst_n       = 1'b0;
      bus.awaddr  = '0;
      bus.awvalid = 1'b0;
      bus.wdata   = '0;
      bus.wstrb   = '0;
      bus.wvalid  = 1'b0;
      bus.bready  = 1'b0;
      bus.araddr  = '0;
      bus.arvalid = 1'b0;
      bus.rready  = 1'b0;

      #3;
      check("rst_rvalid",  {31'd0, bus.rvalid},  32'd0);
      check("rst_bvalid",  {31'd0, bus.bvalid},  32'd0);
      check("rst_arready", {31'd0, bus.arready}, 32'd0);
      check("rst_awready", {31'd0, bus.awready}, 32'd0);
      check("rst_wready",  {31'd0, bus.wready},  32'd0);
      check("rst_rdata",   bus.rdata,            32'd0);
      check("rst_rresp",   {30'd0, bus.rresp},   32'd0);
      check("rst_bresp",   {30'd0, bus.bresp},   32'd0);
      tick;
      tick;
      rst_n = 1'b1;
      #1;
      check("post_rst_awready", {31'd0, bus.awready}, 32'd1);
      check("post_rst_wready",  {31'd0, bus.wready},  32'd1);
      check("post_rst_arready", {31'd0, bus.arready}, 32'd1);
      tick;

      for (int i = 0; i < NVEC; i++) begin
         if (vec[i].wr) begin
            do_write(vec[i].addr, vec[i].data, vec[i].strb, r, lat);
            check($sformatf("vec%0d_bresp", i), {30'd0, r}, {30'd0, vec[i].resp});
            check($sformatf("vec%0d_wlat", i), lat, 32'd1);
         end else begin
            do_read(vec[i].addr, d, r, lat);
            check($sformatf("vec%0d_rresp", i), {30'd0, r}, {30'd0, vec[i].resp});
            check($sformatf("vec%0d_rdata", i), d, vec[i].rdata);
            check($sformatf("vec%0d_rlat", i), lat, 32'd1);
         end
      end

      // W leads AW by five cycles
      bus.awaddr = 32'h30;
      bus.wdata  = 32'h5A5A_0F0F;
      bus.wstrb  = 4'hF;
      bus.wvalid = 1'b1;
      check("skew_wready0", {31'd0, bus.wready}, 32'd1);
      tick;
      bus.wvalid = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         if (k == 5) bus.awvalid = 1'b1;
         #1;
         check($sformatf("skew_wready_c%0d", k), {31'd0, bus.wready}, 32'd0);
         check($sformatf("skew_bvalid_c%0d", k), {31'd0, bus.bvalid}, 32'd0);
         tick;
      end
      bus.awvalid = 1'b0;
      check("skew_bvalid_c6", {31'd0, bus.bvalid}, 32'd0);
      tick;
      check("skew_bvalid_c7", {31'd0, bus.bvalid}, 32'd1);
      check("skew_bresp", {30'd0, bus.bresp}, 32'd0);
      bus.bready = 1'b1;
      tick;
      bus.bready = 1'b0;
      do_read(32'h30, d, r, lat);
      check("skew_readback", d, 32'h5A5A_0F0F);

      // R-channel backpressure, then reset while the response is held
      bus.araddr  = 32'h10;
      bus.arvalid = 1'b1;
      tick;
      bus.arvalid = 1'b0;
      tick;
      for (int k = 0; k < 10; k++) begin
         check($sformatf("bp_rvalid_%0d", k),  {31'd0, bus.rvalid},  32'd1);
         check($sformatf("bp_rdata_%0d", k),   bus.rdata,            32'h0102_0304);
         check($sformatf("bp_arready_%0d", k), {31'd0, bus.arready}, 32'd0);
         tick;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_rvalid",  {31'd0, bus.rvalid},  32'd0);
      check("rst_mid_rdata",   bus.rdata,            32'd0);
      check("rst_mid_arready", {31'd0, bus.arready}, 32'd0);
      tick;
      rst_n = 1'b1;
      tick;

      // Contention alternation starting from a fresh reset
      bus.awaddr  = 32'h40;
      bus.wdata   = 32'h0BAD_F00D;
      bus.wstrb   = 4'hF;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      tick;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      bus.araddr  = 32'h40;
      bus.arvalid = 1'b1;
      #1;
      check("cont1_arready", {31'd0, bus.arready}, 32'd1);
      tick;
      check("cont1_busy_arready", {31'd0, bus.arready}, 32'd0);
      tick;
      check("cont1_rvalid", {31'd0, bus.rvalid}, 32'd1);
      check("cont1_rdata",  bus.rdata,           32'h1212_1212);
      check("cont1_bvalid", {31'd0, bus.bvalid}, 32'd0);
      bus.rready = 1'b1;
      tick;
      bus.rready = 1'b0;
      #1;
      check("cont2_arready", {31'd0, bus.arready}, 32'd0);
      tick;
      check("cont2_bvalid", {31'd0, bus.bvalid}, 32'd1);
      check("cont2_rvalid", {31'd0, bus.rvalid}, 32'd0);
      bus.awaddr  = 32'h44;
      bus.wdata   = 32'h4444_4444;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      tick;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      bus.bready  = 1'b1;
      tick;
      bus.bready = 1'b0;
      #1;
      check("cont3_arready", {31'd0, bus.arready}, 32'd1);
      tick;
      bus.arvalid = 1'b0;
      tick;
      check("cont3_rvalid", {31'd0, bus.rvalid}, 32'd1);
      check("cont3_rdata",  bus.rdata,           32'h0BAD_F00D);
      bus.rready = 1'b1;
      tick;
      bus.rready = 1'b0;
      tick;
      check("cont4_bvalid", {31'd0, bus.bvalid}, 32'd1);
      bus.bready = 1'b1;
      tick;
      bus.bready = 1'b0;
      do_read(32'h44, d, r, lat);
      check("cont4_readback", d, 32'h4444_4444);
      do_read(32'h10, d, r, lat);
      check("ram_kept_after_reset", d, 32'h0102_0304);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
